// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage: shift selector,
// buffered result entry layout and the fixed left-shift amount.
package alu_pkg;

   localparam int ALU_N   = 16;
   localparam int SLL_AMT = 8;

   typedef enum logic [1:0] {
      SH_NONE = 2'b00,
      SH_SLL8 = 2'b01,
      SH_SRA1 = 2'b10,
      SH_RSVD = 2'b11
   } shift_e;

   // Field order matches the flat {data, n, z, ov} packing used by the top level.
   typedef struct packed {
      logic [ALU_N-1:0] data;
      logic             n;
      logic             z;
      logic             ov;
   } res_entry_t;

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry FIFO skid buffer with registered in_ready and out_valid.
// The head entry is read straight out of storage so out_* only move on a pop.
module alu_skid_buf #(
   parameter int W = 19
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic [W-1:0] r_mem [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;
   logic         r_in_ready;
   logic         r_out_valid;
   logic         w_push;
   logic         w_pop;
   logic [1:0]   w_count_next;

   assign w_push    = in_valid & r_in_ready;
   assign w_pop     = r_out_valid & out_ready;
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_mem[r_rd_ptr];

   // Occupancy after this cycle's push/pop.
   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + 2'd1;
         2'b01:   w_count_next = r_count - 2'd1;
         default: w_count_next = r_count;
      endcase
   end

   // Storage, pointers and handshake registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) r_mem[i] <= '0;
         r_wr_ptr    <= 1'b0;
         r_rd_ptr    <= 1'b0;
         r_count     <= 2'd0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count     <= w_count_next;
         r_in_ready  <= (w_count_next < 2'd2);
         r_out_valid <= (w_count_next != 2'd0);
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// Post-ALU stage: optional saturation, shifter, N/Z flags, skid buffer and overflow tracker.
// Optional feature macro: ALU_RESULT_SAT_EN (saturate wrapped results on overflow).
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int N    = 16,
   parameter int CNTW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N-1:0]    func,
   input  logic            ovflag,
   input  logic [1:0]      shift,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N-1:0]    out_data,
   output logic            out_n,
   output logic            out_z,
   output logic            out_ov,
   input  logic            ov_clear,
   output logic            ov_sticky,
   output logic [CNTW-1:0] ov_count
);

   localparam int EW = N + 3;

   shift_e          w_shift;
   logic [N-1:0]    w_src;
   logic [N-1:0]    w_shifted;
   logic [EW-1:0]   w_entry;
   logic [EW-1:0]   w_head;
   logic            w_acc_ov;
   logic [CNTW-1:0] w_cnt_next;
   logic            w_sticky_next;
   logic [CNTW-1:0] r_ov_count;
   logic            r_ov_sticky;

   assign w_shift = shift_e'(shift);

`ifdef ALU_RESULT_SAT_EN
   // Wrapped sum saturates toward the sign the true result would have had.
   always_comb begin
      w_src = func;
      if (ovflag) begin
         if (func[N-1]) w_src = {1'b0, {(N-1){1'b1}}};
         else           w_src = {1'b1, {(N-1){1'b0}}};
      end else begin
         w_src = func;
      end
   end
`else
   assign w_src = func;
`endif

   // Post-ALU shifter; the reserved encoding behaves as no shift.
   always_comb begin
      w_shifted = w_src;
      case (w_shift)
         SH_SLL8: w_shifted = {w_src[N-1-SLL_AMT:0], {SLL_AMT{1'b0}}};
         SH_SRA1: w_shifted = {w_src[N-1], w_src[N-1:1]};
         SH_NONE: w_shifted = w_src;
         default: w_shifted = w_src;
      endcase
   end

   assign w_entry = {w_shifted, w_shifted[N-1], (w_shifted == {N{1'b0}}), ovflag};

   alu_skid_buf #(.W(EW)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (w_entry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (w_head)
   );

   assign out_data = w_head[EW-1:3];
   assign out_n    = w_head[2];
   assign out_z    = w_head[1];
   assign out_ov   = w_head[0];

   assign w_acc_ov = in_valid & in_ready & ovflag;

   // Clear first, then count, so a simultaneous clear and overflow leaves a count of one.
   always_comb begin
      w_cnt_next    = r_ov_count;
      w_sticky_next = r_ov_sticky;
      if (ov_clear) begin
         w_cnt_next    = {CNTW{1'b0}};
         w_sticky_next = 1'b0;
      end else begin
         w_cnt_next    = r_ov_count;
         w_sticky_next = r_ov_sticky;
      end
      if (w_acc_ov) begin
         w_sticky_next = 1'b1;
         if (w_cnt_next != {CNTW{1'b1}}) w_cnt_next = w_cnt_next + {{(CNTW-1){1'b0}}, 1'b1};
         else                            w_cnt_next = w_cnt_next;
      end else begin
         w_sticky_next = w_sticky_next;
      end
   end

   // Overflow tracker registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ov_count  <= {CNTW{1'b0}};
         r_ov_sticky <= 1'b0;
      end else begin
         r_ov_count  <= w_cnt_next;
         r_ov_sticky <= w_sticky_next;
      end
   end

   assign ov_count  = r_ov_count;
   assign ov_sticky = r_ov_sticky;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage (N=16, CNTW=8): directed steps plus
// random traffic against a queue-based reference model.
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] func;
   logic        ovflag;
   logic [1:0]  shift;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_n;
   logic        out_z;
   logic        out_ov;
   logic        ov_clear;
   logic        ov_sticky;
   logic [7:0]  ov_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] data;
      logic        n;
      logic        z;
      logic        ov;
   } ent_t;

   ent_t       q[$];
   logic       m_in_ready = 1'b1;
   logic       m_sticky   = 1'b0;
   int         m_cnt      = 0;

   alu_result_stage #(.N(16), .CNTW(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .func(func), .ovflag(ovflag), .shift(shift), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_n(out_n), .out_z(out_z),
      .out_ov(out_ov), .ov_clear(ov_clear), .ov_sticky(ov_sticky), .ov_count(ov_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic ent_t model(input logic [15:0] f, input logic ov, input logic [1:0] sh);
      ent_t        e;
      logic [15:0] s;
      s = f;
`ifdef ALU_RESULT_SAT_EN
      if (ov) s = f[15] ? 16'h7FFF : 16'h8000;
`endif
      case (sh)
         2'd1:    e.data = 16'((32'(s) * 256) % 65536);
         2'd2:    e.data = 16'($signed(s) >>> 1);
         default: e.data = s;
      endcase
      e.n  = e.data[15];
      e.z  = (e.data == 16'd0);
      e.ov = ov;
      return e;
   endfunction

   task automatic compare_all();
      chk("in_ready", 32'(in_ready), 32'(m_in_ready));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("out_data", 32'(out_data), 32'(q[0].data));
         chk("out_n", 32'(out_n), 32'(q[0].n));
         chk("out_z", 32'(out_z), 32'(q[0].z));
         chk("out_ov", 32'(out_ov), 32'(q[0].ov));
      end
      chk("ov_sticky", 32'(ov_sticky), 32'(m_sticky));
      chk("ov_count", 32'(ov_count), 32'(m_cnt));
   endtask

   // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
   task automatic cyc(input logic iv, input logic [15:0] f, input logic ov,
                      input logic [1:0] sh, input logic ordy, input logic clr);
      logic acc, pop;
      in_valid = iv; func = f; ovflag = ov; shift = sh; out_ready = ordy; ov_clear = clr;
      @(posedge clk);
      acc = iv && m_in_ready;
      pop = ordy && (q.size() != 0);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(model(f, ov, sh));
      if (clr) begin m_cnt = 0; m_sticky = 1'b0; end
      if (acc && ov) begin
         m_sticky = 1'b1;
         if (m_cnt != 255) m_cnt++;
      end
      m_in_ready = (q.size() < 2);
      #1;
      compare_all();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; func = 16'h0; ovflag = 1'b0; shift = 2'd0;
      out_ready = 1'b0; ov_clear = 1'b0;
      #2;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_flags", 32'({out_n, out_z, out_ov, ov_sticky}), 32'd0);
      chk("rst_ov_count", 32'(ov_count), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // Passthrough
      cyc(1'b1, 16'h1234, 1'b0, 2'd0, 1'b1, 1'b0);
      chk("pass_data", 32'(out_data), 32'h1234);
      chk("pass_nz", 32'({out_valid, out_n, out_z}), 32'b100);
      cyc(1'b0, 16'h0, 1'b0, 2'd0, 1'b1, 1'b0);
      chk("pass_one_cycle", 32'(out_valid), 32'd0);

      // Shifts
      cyc(1'b1, 16'h00AB, 1'b0, 2'd1, 1'b1, 1'b0);
      chk("sll8_data", 32'(out_data), 32'hAB00);
      chk("sll8_n", 32'(out_n), 32'd1);
      cyc(1'b1, 16'h8002, 1'b0, 2'd2, 1'b1, 1'b0);
      chk("sra1_data", 32'(out_data), 32'hC001);
      chk("sra1_n", 32'(out_n), 32'd1);
      cyc(1'b1, 16'h0001, 1'b0, 2'd2, 1'b1, 1'b0);
      chk("sra1_zero", 32'({out_data, out_z}), 32'h00001);
      cyc(1'b1, 16'h5555, 1'b0, 2'd3, 1'b1, 1'b0);
      chk("rsvd_none", 32'(out_data), 32'h5555);
      cyc(1'b0, 16'h0, 1'b0, 2'd0, 1'b1, 1'b0);

      // Backpressure
      cyc(1'b1, 16'd1, 1'b0, 2'd0, 1'b0, 1'b0);
      cyc(1'b1, 16'd2, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      cyc(1'b1, 16'd3, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("bp_hold_head", 32'(out_data), 32'd1);
      cyc(1'b1, 16'd3, 1'b0, 2'd0, 1'b1, 1'b0);
      chk("bp_second", 32'(out_data), 32'd2);
      cyc(1'b1, 16'd3, 1'b0, 2'd0, 1'b1, 1'b0);
      chk("bp_third", 32'(out_data), 32'd3);
      cyc(1'b0, 16'd0, 1'b0, 2'd0, 1'b1, 1'b0);
      chk("bp_drained", 32'(out_valid), 32'd0);

      // Overflow tracking
      cyc(1'b1, 16'h8000, 1'b1, 2'd0, 1'b1, 1'b0);
`ifdef ALU_RESULT_SAT_EN
      chk("ov_data", 32'(out_data), 32'h7FFF);
`else
      chk("ov_data", 32'(out_data), 32'h8000);
`endif
      chk("ov_flags", 32'({out_ov, ov_sticky, ov_count}), 32'h301);
      cyc(1'b1, 16'h7000, 1'b1, 2'd0, 1'b1, 1'b0);
      chk("ov_count2", 32'(ov_count), 32'd2);
      cyc(1'b1, 16'h8000, 1'b1, 2'd0, 1'b1, 1'b1);
      chk("ov_clear_with_ov", 32'({ov_sticky, ov_count}), 32'h101);
      cyc(1'b0, 16'h0, 1'b0, 2'd0, 1'b1, 1'b1);
      chk("ov_clear_only", 32'({ov_sticky, ov_count}), 32'h000);

      // Counter saturation
      for (int i = 0; i < 300; i++)
         cyc(1'b1, 16'($urandom), 1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
      chk("ov_count_sat", 32'(ov_count), 32'hFF);

      // Asynchronous reset with two entries buffered
      cyc(1'b1, 16'hAAAA, 1'b0, 2'd0, 1'b0, 1'b0);
      cyc(1'b1, 16'hBBBB, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("pre_rst_full", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      chk("arst_ov_count", 32'(ov_count), 32'd0);
      q.delete(); m_in_ready = 1'b1; m_sticky = 1'b0; m_cnt = 0;
      @(negedge clk) rst = 1'b0;

      // Random traffic
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) == 0),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) != 0),
             1'($urandom_range(0, 15) == 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
